q8_8_addsub_arb: RTL

Q8_8_ADDSUB_ARB -- requirements
Module: q8_8_addsub_arb

---
 rtl/q8_8_addsub_arb.sv | 115 +++++++++++
 1 files changed

// File: rtl/q8_8_addsub_arb.sv
// Shared Q8.8 add/sub datapath with round-robin arbitration over N_REQ requesters.
// One transaction in flight: IDLE grants and latches, EXEC computes, RESP holds until taken.
module q8_8_addsub_arb #(
  parameter int unsigned BUS_WIDTH = 16,
  parameter int unsigned N_REQ     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*BUS_WIDTH-1:0]   req_op1,
  input  logic [N_REQ*BUS_WIDTH-1:0]   req_op2,
  input  logic [N_REQ-1:0]             req_sub,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(N_REQ)-1:0]     rsp_id,
  output logic [BUS_WIDTH:0]           rsp_result,
  output logic                         rsp_ovf,
  output logic [15:0]                  txn_count
);

  localparam int unsigned IdW = $clog2(N_REQ);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e               state_q, state_d;
  logic [IdW-1:0]       last_grant_q, grant_idx, cand, id_q;
  logic                 grant_found, accept;
  logic [BUS_WIDTH-1:0] op1_q, op2_q;
  logic                 sub_q;
  logic [BUS_WIDTH:0]   op1_ext, op2_ext, sum;

  logic                 rsp_valid_q, rsp_ovf_q;
  logic [IdW-1:0]       rsp_id_q;
  logic [BUS_WIDTH:0]   rsp_result_q;
  logic [15:0]          txn_count_q;

  // Search begins one past the last winner and wraps, so the first hit is the fair choice.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      cand = IdW'((int'(last_grant_q) + k) % int'(N_REQ));
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign accept = (state_q == StIdle) && grant_found;

  always_comb begin
    req_ready = '0;
    if (accept && rst_n) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (grant_found) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign op1_ext = {op1_q[BUS_WIDTH-1], op1_q};
  assign op2_ext = {op2_q[BUS_WIDTH-1], op2_q};
  assign sum     = sub_q ? (op1_ext - op2_ext) : (op1_ext + op2_ext);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= IdW'(N_REQ - 1);
      op1_q        <= '0;
      op2_q        <= '0;
      sub_q        <= 1'b0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
      txn_count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant_q <= grant_idx;
        op1_q        <= req_op1[grant_idx*BUS_WIDTH +: BUS_WIDTH];
        op2_q        <= req_op2[grant_idx*BUS_WIDTH +: BUS_WIDTH];
        sub_q        <= req_sub[grant_idx];
        id_q         <= grant_idx;
      end
      if (state_q == StExec) begin
        rsp_valid_q  <= 1'b1;
        rsp_id_q     <= id_q;
        rsp_result_q <= sum;
        rsp_ovf_q    <= sum[BUS_WIDTH] ^ sum[BUS_WIDTH-1];
      end else if (rsp_valid_q && rsp_ready) begin
        rsp_valid_q <= 1'b0;
        txn_count_q <= txn_count_q + 16'd1;
      end
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign txn_count  = txn_count_q;

endmodule
